// File: rtl/pwm_capture_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pwm_pkg : shared constants and FSM state type for the PWM capture block
// Rev 1.0
// ---------------------------------------------------------------------------
package pwm_pkg;

  localparam int          CNT_W      = 12;
  localparam int          TIMEOUT    = 4095;
  localparam logic [10:0] NONOVERLAP = 11'h040;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEAS_HI = 2'd1,
    MEAS_LO = 2'd2
  } pwm_cap_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_capture_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pwm_capture_if : PWM inputs, error clear and measurement results
// Rev 1.0
// ---------------------------------------------------------------------------
interface pwm_capture_if
  import pwm_pkg::*;
#(
  parameter int CNT_W = pwm_pkg::CNT_W
);

  logic             pwm_in;
  logic             pwm_cmp;
  logic             clr_err;
  logic [CNT_W-1:0] duty;
  logic [CNT_W-1:0] period;
  logic             vld;
  logic             stuck_hi;
  logic             stuck_lo;
  logic             sat;
  logic             ovlp_err;

  modport master (
    output pwm_in, pwm_cmp, clr_err,
    input  duty, period, vld, stuck_hi, stuck_lo, sat, ovlp_err
  );

  modport slave (
    input  pwm_in, pwm_cmp, clr_err,
    output duty, period, vld, stuck_hi, stuck_lo, sat, ovlp_err
  );

endinterface
`default_nettype wire

// File: rtl/pwm_capture_sync_edge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pwm_sync_edge : two-flop synchronizer with rise/fall detect on the 2nd flop
// Rev 1.0
// ---------------------------------------------------------------------------
module pwm_sync_edge
  import pwm_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~dly_q;
  assign fall_o = ~sync_q & dly_q;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pwm_capture : measures PWM high time and period, flags stuck/overlap/saturation
// Rev 1.0
// ---------------------------------------------------------------------------
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W   = pwm_pkg::CNT_W,
  parameter int TIMEOUT = pwm_pkg::TIMEOUT
) (
  input  logic         clk,
  input  logic         rst_n,
  pwm_capture_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - CNT_ONE;
  localparam logic [CNT_W-1:0] TO_PRE  = CNT_W'(TIMEOUT - 1);

  logic in_sync;
  logic in_rise;
  logic in_fall;
  logic cmp_sync;
  logic any_edge;
  logic timeout_hit;
  logic sat_hit;
  logic hi_load;
  logic res_load;

  pwm_cap_state_t   state_q;
  pwm_cap_state_t   state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] ecnt_q;
  logic [CNT_W-1:0] ecnt_d;
  logic [CNT_W-1:0] hi_cnt_q;
  logic [CNT_W-1:0] duty_q;
  logic [CNT_W-1:0] period_q;
  logic             vld_q;
  logic             stuck_hi_q;
  logic             stuck_hi_d;
  logic             stuck_lo_q;
  logic             stuck_lo_d;
  logic             sat_q;
  logic             sat_d;
  logic             ovlp_q;
  logic             ovlp_d;

  pwm_sync_edge u_sync_in (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (bus.pwm_in),
    .sync_o (in_sync),
    .rise_o (in_rise),
    .fall_o (in_fall)
  );

  pwm_sync_edge u_sync_cmp (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (bus.pwm_cmp),
    .sync_o (cmp_sync),
    .rise_o (),
    .fall_o ()
  );

  assign any_edge = in_rise | in_fall;

  // cnt spans rise-to-rise for the measurement; ecnt spans edge-to-edge for the stuck timeout
  always_comb begin
    cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    ecnt_d = (ecnt_q == CNT_MAX) ? ecnt_q : ecnt_q + CNT_ONE;
    if (in_rise) begin
      cnt_d = CNT_ONE;
    end
    if (any_edge) begin
      ecnt_d = CNT_ONE;
    end
  end

  // Both fire only on the cycle the count first arrives, so a held condition cannot re-set a cleared flag
  assign timeout_hit = (ecnt_q == TO_PRE) && !any_edge;
  assign sat_hit     = (cnt_q == CNT_PRE) && !in_rise && (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hi_load  = 1'b0;
    res_load = 1'b0;
    if (timeout_hit) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_rise) begin
            state_d = MEAS_HI;
          end
        end
        MEAS_HI: begin
          if (in_fall) begin
            hi_load = 1'b1;
            state_d = MEAS_LO;
          end
        end
        MEAS_LO: begin
          if (in_rise) begin
            res_load = 1'b1;
            state_d  = MEAS_HI;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Sticky flags: a set condition outranks clr_err in the same cycle
  always_comb begin
    stuck_hi_d = stuck_hi_q;
    stuck_lo_d = stuck_lo_q;
    sat_d      = sat_q;
    ovlp_d     = ovlp_q;
    if (any_edge || bus.clr_err) begin
      stuck_hi_d = 1'b0;
      stuck_lo_d = 1'b0;
    end
    if (timeout_hit) begin
      stuck_hi_d = in_sync;
      stuck_lo_d = ~in_sync;
    end
    if (bus.clr_err) begin
      sat_d  = 1'b0;
      ovlp_d = 1'b0;
    end
    if (sat_hit) begin
      sat_d = 1'b1;
    end
    if (in_sync && cmp_sync) begin
      ovlp_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      ecnt_q     <= '0;
      hi_cnt_q   <= '0;
      duty_q     <= '0;
      period_q   <= '0;
      vld_q      <= 1'b0;
      stuck_hi_q <= 1'b0;
      stuck_lo_q <= 1'b0;
      sat_q      <= 1'b0;
      ovlp_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ecnt_q     <= ecnt_d;
      vld_q      <= res_load;
      stuck_hi_q <= stuck_hi_d;
      stuck_lo_q <= stuck_lo_d;
      sat_q      <= sat_d;
      ovlp_q     <= ovlp_d;
      if (hi_load) begin
        hi_cnt_q <= cnt_q;
      end
      if (res_load) begin
        duty_q   <= hi_cnt_q;
        period_q <= cnt_q;
      end
    end
  end

  assign bus.duty     = duty_q;
  assign bus.period   = period_q;
  assign bus.vld      = vld_q;
  assign bus.stuck_hi = stuck_hi_q;
  assign bus.stuck_lo = stuck_lo_q;
  assign bus.sat      = sat_q;
  assign bus.ovlp_err = ovlp_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pwm_capture : directed self-checking bench for pwm_capture
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pwm_capture;
  import pwm_pkg::*;

  logic clk;
  logic rst_n;

  int     n_assert;
  int     n_fail;
  int     vld_cnt;
  longint cyc;
  longint last_vld_cyc;
  longint prev_vld_cyc;
  logic [11:0] last_duty;
  logic [11:0] last_period;
  int     v0;

  pwm_capture_if #(.CNT_W(12)) bus ();

  pwm_capture #(
    .CNT_W   (12),
    .TIMEOUT (4095)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle, sampling on the falling edge and logging any vld pulse
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.vld === 1'b1) begin
      vld_cnt++;
      prev_vld_cyc = last_vld_cyc;
      last_vld_cyc = cyc;
      last_duty    = bus.duty;
      last_period  = bus.period;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pwm_period(input int h, input int p);
    bus.pwm_in = 1'b1;
    steps(h);
    bus.pwm_in = 1'b0;
    steps(p - h);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    vld_cnt      = 0;
    cyc          = 0;
    last_vld_cyc = 0;
    prev_vld_cyc = 0;
    last_duty    = '0;
    last_period  = '0;
    rst_n        = 1'b0;
    bus.pwm_in   = 1'b0;
    bus.pwm_cmp  = 1'b0;
    bus.clr_err  = 1'b0;
    steps(5);

    // Reset state
    check("rst_duty", 32'(bus.duty), 32'd0);
    check("rst_period", 32'(bus.period), 32'd0);
    check("rst_vld", 32'(bus.vld), 32'd0);
    check("rst_stuck_hi", 32'(bus.stuck_hi), 32'd0);
    check("rst_stuck_lo", 32'(bus.stuck_lo), 32'd0);
    check("rst_sat", 32'(bus.sat), 32'd0);
    check("rst_ovlp", 32'(bus.ovlp_err), 32'd0);
    rst_n = 1'b1;
    steps(3);

    // 1: H=512 P=2048, first rise gives no result
    pwm_period(512, 2048);
    check("t1_no_first_vld", 32'(vld_cnt), 32'd0);
    for (int k = 0; k < 3; k++) pwm_period(512, 2048);
    check("t1_vld_count", 32'(vld_cnt), 32'd3);
    check("t1_duty", 32'(last_duty), 32'd512);
    check("t1_period", 32'(last_period), 32'd2048);
    check("t1_spacing", 32'(last_vld_cyc - prev_vld_cyc), 32'd2048);

    // 2: H=1 then H=2047, period fixed at 2048
    pwm_period(1, 2048);
    pwm_period(1, 2048);
    check("t2_vld_count_a", 32'(vld_cnt), 32'd5);
    check("t2_duty_min", 32'(last_duty), 32'd1);
    check("t2_period_a", 32'(last_period), 32'd2048);
    pwm_period(2047, 2048);
    pwm_period(2047, 2048);
    check("t2_vld_count_b", 32'(vld_cnt), 32'd7);
    check("t2_duty_max", 32'(last_duty), 32'd2047);
    check("t2_period_b", 32'(last_period), 32'd2048);

    // 3: one high phase then hold low for 5000 cycles
    bus.pwm_in = 1'b1;
    steps(512);
    bus.pwm_in = 1'b0;
    check("t3_vld_count_a", 32'(vld_cnt), 32'd8);
    steps(4090);
    check("t3_stuck_lo_early", 32'(bus.stuck_lo), 32'd0);
    steps(10);
    check("t3_stuck_lo", 32'(bus.stuck_lo), 32'd1);
    check("t3_stuck_hi", 32'(bus.stuck_hi), 32'd0);
    check("t3_state_idle", 32'(dut.state_q), 32'(IDLE));
    check("t3_sat", 32'(bus.sat), 32'd1);
    steps(900);
    check("t3_no_vld", 32'(vld_cnt), 32'd8);
    pwm_period(512, 2048);
    check("t3_stuck_lo_cleared", 32'(bus.stuck_lo), 32'd0);
    check("t3_no_vld_restart", 32'(vld_cnt), 32'd8);
    pwm_period(512, 2048);
    check("t3_vld_return", 32'(vld_cnt), 32'd9);
    check("t3_duty", 32'(last_duty), 32'd512);
    check("t3_period", 32'(last_period), 32'd2048);

    // 4: overlap detection, clear, and set-beats-clear
    check("t4_ovlp_init", 32'(bus.ovlp_err), 32'd0);
    bus.pwm_in  = 1'b1;
    bus.pwm_cmp = 1'b1;
    steps(2);
    bus.pwm_in  = 1'b0;
    bus.pwm_cmp = 1'b0;
    steps(10);
    check("t4_ovlp_set", 32'(bus.ovlp_err), 32'd1);
    steps(20);
    check("t4_ovlp_sticky", 32'(bus.ovlp_err), 32'd1);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    steps(2);
    check("t4_ovlp_clr", 32'(bus.ovlp_err), 32'd0);
    check("t4_sat_clr", 32'(bus.sat), 32'd0);
    bus.pwm_in  = 1'b1;
    bus.pwm_cmp = 1'b1;
    steps(5);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    steps(3);
    bus.pwm_in  = 1'b0;
    bus.pwm_cmp = 1'b0;
    steps(5);
    check("t4_set_wins", 32'(bus.ovlp_err), 32'd1);

    // 5: 5000-cycle period saturates the 12-bit counter
    bus.pwm_in = 1'b1;
    steps(100);
    check("t5_sat_before", 32'(bus.sat), 32'd0);
    steps(900);
    bus.pwm_in = 1'b0;
    steps(4000);
    pwm_period(1000, 5000);
    bus.pwm_in = 1'b1;
    steps(100);
    check("t5_duty", 32'(last_duty), 32'd1000);
    check("t5_period_sat", 32'(last_period), 32'd4095);
    check("t5_sat", 32'(bus.sat), 32'd1);
    check("t5_no_stuck", 32'(bus.stuck_lo), 32'd0);

    // 6: reset in the middle of MEAS_LO
    steps(900);
    bus.pwm_in = 1'b0;
    steps(500);
    rst_n = 1'b0;
    steps(2);
    check("t6_duty", 32'(bus.duty), 32'd0);
    check("t6_period", 32'(bus.period), 32'd0);
    check("t6_vld", 32'(bus.vld), 32'd0);
    check("t6_sat", 32'(bus.sat), 32'd0);
    check("t6_ovlp", 32'(bus.ovlp_err), 32'd0);
    check("t6_stuck", 32'({bus.stuck_hi, bus.stuck_lo}), 32'd0);
    check("t6_state", 32'(dut.state_q), 32'(IDLE));
    rst_n = 1'b1;
    steps(5);
    v0 = vld_cnt;
    pwm_period(300, 1000);
    check("t6_no_vld_first", 32'(vld_cnt - v0), 32'd0);
    pwm_period(300, 1000);
    check("t6_vld_second", 32'(vld_cnt - v0), 32'd1);
    check("t6_duty_new", 32'(last_duty), 32'd300);
    check("t6_period_new", 32'(last_period), 32'd1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
